edge_pulse_generator: RTL
=========================

Name: edge_pulse_generator

Overview:
- Transmit end of the edge-detection path: turns single-cycle event strobes into clean level transitions on a registered output line.
- Each event is guaranteed to produce one detectable edge for a downstream edge_detector, including one sampling in a slower clock domain.
- Every output phase lasts at least HOLD_CYCLES clocks.
- Events arriving while an edge is in flight are queued in a saturating pending counter.

Parameters:
- HOLD_CYCLES, 4: minimum clocks each output level is held (legal range >= 1).
- PEND_W, 4: width of the pending-event counter; maximum queued events is 2^PEND_W-1.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state.
- event_in  input  1  one-cycle event strobe; each high cycle is one event.
- toggle_mode  input  1  0 = pulse encoding, 1 = toggle encoding; sampled only in IDLE.
- clear_ovf  input  1  synchronous clear of the overflow flag.
- signal_out  output  1  registered encoded line driven to the edge detector.
- busy  output  1  high whenever state != IDLE.
- pending  output  PEND_W  count of queued events not yet transmitted.
- overflow  output  1  sticky flag: an event was dropped because pending was saturated.

Behaviour:
- Reset (reset=0, asynchronous):
  - signal_out=0, busy=0, pending=0, overflow=0.
  - State=IDLE, hold counter=0, latched mode=0.
  - Reset asserted mid-operation aborts any phase immediately, and signal_out returns to 0.
- States: IDLE, HIGH, LOW (pulse mode); IDLE, HOLD (toggle mode). The mode is latched on leaving IDLE.
- IDLE:
  - event_in=1 at edge N: latch toggle_mode and start the hold counter at HOLD_CYCLES-1.
  - Pulse mode: go to HIGH, signal_out=1 from edge N.
  - Toggle mode: go to HOLD, signal_out inverts from edge N.
  - Latency is one clock: the output changes on the same edge that samples the event.
- HIGH: signal_out=1 for exactly HOLD_CYCLES clocks, then go to LOW with signal_out=0 and the counter reloaded.
- LOW: signal_out=0 for exactly HOLD_CYCLES clocks. At expiry:
  - pending>0: decrement pending, go to HIGH.
  - pending=0: go to IDLE.
  - A rising edge therefore never follows a falling edge in fewer than HOLD_CYCLES clocks.
- HOLD: signal_out is held for HOLD_CYCLES clocks. At expiry:
  - pending>0: decrement pending, invert signal_out, stay in HOLD.
  - pending=0: go to IDLE, keeping signal_out at its current level.
- Queuing:
  - event_in=1 while busy (or in the same cycle IDLE is re-entered) increments pending.
  - Increment and dequeue in the same cycle leave pending unchanged; the event is not lost.
- Saturation:
  - event_in=1 with pending=2^PEND_W-1 and no dequeue that cycle drops the event and sets overflow=1.
  - If a dequeue happens that cycle, the event is accepted and pending stays at maximum.
- overflow:
  - Cleared by clear_ovf=1 on the next edge.
  - A set and a clear in the same cycle resolve to set.
- toggle_mode changes while busy are ignored until the next IDLE departure.
- Unused pending width never wraps; all counter arithmetic saturates at both ends.

Decomposition:
- Shared package:
  - State encoding constants (ST_IDLE, ST_HIGH, ST_LOW, ST_HOLD).
  - Mode constants (MODE_PULSE=0, MODE_TOGGLE=1).
- One natural sub-module, hold_timer: a loadable down-counter with load, enable and a done flag, sized by clog2(HOLD_CYCLES).
- The FSM, pending counter and overflow logic live in the top module.

Test Plan:
1. Pulse mode, single event_in at cycle 2 -> signal_out=1 at cycles 2-5, 0 at cycles 6-9; busy falls after cycle 9; pending stays 0; an edge_detector on signal_out fires exactly once.
2. Pulse mode, event_in at cycles 2, 3, 4 -> pending reaches 2, then three high pulses each 4 cycles wide separated by 4-cycle lows; pending returns to 0; total busy time 24 cycles.
3. Toggle mode, events at cycles 2 and 3 -> signal_out rises at cycle 2 and falls at cycle 6, then stays 0 in IDLE; a both-edge detector counts 2 edges.
4. PEND_W=2, 5 events back-to-back while busy -> pending saturates at 3 and overflow=1. Check the simultaneous dequeue+event case keeps pending=3 without setting overflow. Then clear_ovf together with a new overflowing event -> overflow stays 1.
5. Reset driven low mid-HIGH, asynchronously between clock edges -> signal_out, busy and pending read 0 before the next edge; after release the first event_in behaves as in test 1.
6. toggle_mode flipped while in HIGH -> current pulse/LOW sequence completes unchanged; the next event from IDLE uses toggle encoding.

Source files
------------

// File: rtl/edge_pulse_generator_pkg.sv
// Shared encodings for the edge pulse generator: FSM states and the
// line-encoding modes selected by toggle_mode.
package edge_pulse_generator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic MODE_PULSE  = 1'b0;
  localparam logic MODE_TOGGLE = 1'b1;

endpackage

// File: rtl/edge_pulse_generator_hold_timer.sv
// Loadable down-counter that times one output phase; o_done is high while
// the count sits at zero, i.e. during the last clock of a phase.
module hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_done
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] r_count;

  // Load wins over counting; the count parks at zero rather than wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/edge_pulse_generator.sv
// Encodes single-cycle event strobes as level transitions on a registered
// line, holding every level for HOLD_CYCLES clocks and queueing extra events.
module edge_pulse_generator
  import edge_pulse_generator_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              event_in,
  input  logic              toggle_mode,
  input  logic              clear_ovf,
  output logic              signal_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_sig;
  logic              w_sig_next;
  logic              r_mode;
  logic [PEND_W-1:0] r_pend;
  logic              r_ovf;
  logic              w_load;
  logic              w_deq;
  logic              w_inc;
  logic              w_drop;
  logic              w_leave_idle;
  logic              w_done;

  hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_timer (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_load (w_load),
    .i_en   (r_state != ST_IDLE),
    .o_done (w_done)
  );

  assign w_leave_idle = (r_state == ST_IDLE) && (event_in || (r_pend != '0));

  // A queued event left behind by a same-cycle return to IDLE launches on its own.
  always_comb begin
    w_next_state = r_state;
    w_sig_next   = r_sig;
    w_load       = 1'b0;
    w_deq        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_leave_idle) begin
          w_load = 1'b1;
          w_deq  = (r_pend != '0);
          if (toggle_mode == MODE_TOGGLE) begin
            w_next_state = ST_HOLD;
            w_sig_next   = ~r_sig;
          end else begin
            w_next_state = ST_HIGH;
            w_sig_next   = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (w_done) begin
          w_next_state = ST_LOW;
          w_sig_next   = 1'b0;
          w_load       = 1'b1;
        end
      end
      ST_LOW, ST_HOLD: begin
        if (w_done) begin
          if (r_pend != '0) begin
            w_deq  = 1'b1;
            w_load = 1'b1;
            if (r_mode == MODE_TOGGLE) begin
              w_next_state = ST_HOLD;
              w_sig_next   = ~r_sig;
            end else begin
              w_next_state = ST_HIGH;
              w_sig_next   = 1'b1;
            end
          end else begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_sig_next   = 1'b0;
      end
    endcase
  end

  assign w_inc  = event_in && ((r_state != ST_IDLE) || (r_pend != '0));
  assign w_drop = w_inc && !w_deq && (r_pend == PEND_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_sig   <= 1'b0;
      r_mode  <= MODE_PULSE;
    end else begin
      r_state <= w_next_state;
      r_sig   <= w_sig_next;
      if (w_leave_idle) begin
        r_mode <= toggle_mode;
      end
    end
  end

  // Enqueue and dequeue together cancel out, so a full queue still accepts then.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_inc && !w_deq && !w_drop) begin
        r_pend <= r_pend + PEND_W'(1);
      end else if (w_deq && !w_inc) begin
        r_pend <= r_pend - PEND_W'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (clear_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign signal_out = r_sig;
  assign busy       = (r_state != ST_IDLE);
  assign pending    = r_pend;
  assign overflow   = r_ovf;

endmodule
